// File: rtl/digitizer_pkg.sv
// Shared types and default widths for the digitizer clocking blocks.
// The MMCM phase-shift sequencer uses the state enum and parameter defaults below.
package digitizer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    SETTLE = 2'd3
  } ps_state_e;

  localparam int DEF_CW  = 12;
  localparam int DEF_PW  = 16;
  localparam int DEF_TW  = 8;
  localparam int DEF_GAP = 4;

endpackage

// File: rtl/sat_updown_cnt.sv
// Signed up/down-by-one counter that clamps at the W-bit signed limits.
module sat_updown_cnt #(
  parameter int W = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clr_i,
  input  logic                inc_i,
  input  logic                dec_i,
  output logic signed [W-1:0] cnt_o
);

  localparam logic [W-1:0] MAX_C = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_C = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] ONE_C = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX_C)) begin
      cnt_d = cnt_q + ONE_C;
    end else if (dec_i && (cnt_q != MIN_C)) begin
      cnt_d = cnt_q - ONE_C;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mmcm_ps_sequencer.sv
// Steps the MMCM dynamic phase shifter by a signed count, one psen per step,
// with psdone timeout, loss-of-lock abort and a saturating net phase tally.
module mmcm_ps_sequencer
  import digitizer_pkg::*;
#(
  parameter int CW  = DEF_CW,
  parameter int PW  = DEF_PW,
  parameter int TW  = DEF_TW,
  parameter int GAP = DEF_GAP
) (
  input  logic                 lb_clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic signed [CW-1:0] steps,
  input  logic                 abort,
  input  logic                 phase_clr,
  input  logic                 mmcm_locked,
  input  logic                 psdone,
  output logic                 psen,
  output logic                 psincdec,
  output logic                 busy,
  output logic                 done,
  output logic                 err_timeout,
  output logic                 err_unlock,
  output logic signed [PW-1:0] phase_acc,
  output logic        [CW-1:0] remaining
);

  localparam logic [TW-1:0] TMO_MAX_C  = '1;
  localparam logic [TW-1:0] TMO_ONE_C  = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [3:0]    GAP_LAST_C = 4'(GAP - 1);
  localparam logic [CW-1:0] ONE_C      = {{(CW-1){1'b0}}, 1'b1};

  ps_state_e     state_q, state_d;
  logic [CW-1:0] remaining_q, remaining_d;
  logic          psincdec_q, psincdec_d;
  logic          done_q, done_d;
  logic          err_timeout_q, err_timeout_d;
  logic          err_unlock_q, err_unlock_d;
  logic          abort_q, abort_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [3:0]    gap_q, gap_d;
  logic          acc_inc, acc_dec, acc_clr;
  logic [CW-1:0] steps_mag;

  // Two's-complement magnitude; the most negative count maps to 2**(CW-1).
  assign steps_mag = steps[CW-1] ? (~steps + ONE_C) : steps;

  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    psincdec_d    = psincdec_q;
    done_d        = 1'b0;
    err_timeout_d = err_timeout_q;
    err_unlock_d  = err_unlock_q;
    abort_d       = abort_q;
    tmo_d         = tmo_q;
    gap_d         = gap_q;
    acc_inc       = 1'b0;
    acc_dec       = 1'b0;
    acc_clr       = 1'b0;
    psen          = 1'b0;

    if ((state_q != IDLE) && abort) abort_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (!mmcm_locked) begin
            err_unlock_d = 1'b1;
            done_d       = 1'b1;
          end else begin
            err_timeout_d = 1'b0;
            err_unlock_d  = 1'b0;
            psincdec_d    = ~steps[CW-1];
            remaining_d   = steps_mag;
            abort_d       = 1'b0;
            if (steps_mag == '0) done_d = 1'b1;
            else                 state_d = ISSUE;
          end
        end else if (phase_clr) begin
          acc_clr = 1'b1;
        end
      end

      ISSUE: begin
        if (!mmcm_locked) begin
          err_unlock_d = 1'b1;
          state_d      = IDLE;
          done_d       = 1'b1;
          abort_d      = 1'b0;
        end else begin
          psen        = 1'b1;
          remaining_d = remaining_q - ONE_C;
          tmo_d       = '0;
          state_d     = WAIT;
        end
      end

      WAIT: begin
        // A lock loss wins over a coincident psdone: that step is not trusted.
        if (!mmcm_locked) begin
          err_unlock_d = 1'b1;
          state_d      = IDLE;
          done_d       = 1'b1;
          abort_d      = 1'b0;
        end else if (psdone) begin
          acc_inc = psincdec_q;
          acc_dec = ~psincdec_q;
          gap_d   = '0;
          state_d = SETTLE;
        end else if (tmo_q == TMO_MAX_C) begin
          err_timeout_d = 1'b1;
          state_d       = IDLE;
          done_d        = 1'b1;
          abort_d       = 1'b0;
        end else begin
          tmo_d = tmo_q + TMO_ONE_C;
        end
      end

      SETTLE: begin
        if (!mmcm_locked) begin
          err_unlock_d = 1'b1;
          state_d      = IDLE;
          done_d       = 1'b1;
          abort_d      = 1'b0;
        end else if (gap_q == GAP_LAST_C) begin
          if ((remaining_q == '0) || abort_q || abort) begin
            state_d = IDLE;
            done_d  = 1'b1;
            abort_d = 1'b0;
          end else begin
            state_d = ISSUE;
          end
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge lb_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      remaining_q   <= '0;
      psincdec_q    <= 1'b0;
      done_q        <= 1'b0;
      err_timeout_q <= 1'b0;
      err_unlock_q  <= 1'b0;
      abort_q       <= 1'b0;
      tmo_q         <= '0;
      gap_q         <= '0;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      psincdec_q    <= psincdec_d;
      done_q        <= done_d;
      err_timeout_q <= err_timeout_d;
      err_unlock_q  <= err_unlock_d;
      abort_q       <= abort_d;
      tmo_q         <= tmo_d;
      gap_q         <= gap_d;
    end
  end

  sat_updown_cnt #(.W(PW)) u_phase_acc (
    .clk_i  (lb_clk),
    .rst_ni (rst_n),
    .clr_i  (acc_clr),
    .inc_i  (acc_inc),
    .dec_i  (acc_dec),
    .cnt_o  (phase_acc)
  );

  assign busy        = (state_q != IDLE);
  assign psincdec    = psincdec_q;
  assign done        = done_q;
  assign err_timeout = err_timeout_q;
  assign err_unlock  = err_unlock_q;
  assign remaining   = remaining_q;

endmodule
